// File: rtl/aes256_pkg.sv
// Shared constants and types for the AES-256 output path.
// Block width, collector state encoding and block type.
package aes256_pkg;

    localparam int AES_BLOCK_BITS  = 128;
    localparam int AES_BLOCK_BYTES = 16;

    typedef logic [AES_BLOCK_BITS-1:0] aes_block_t;

    typedef enum logic [1:0] {
        S_REQ,
        S_COLLECT,
        S_WAIT
    } coll_state_t;

endpackage

// File: rtl/aes256_block_fifo.sv
// DEPTH x 128-bit synchronous FIFO with level and synchronous clear.
// Head entry is read combinationally; an empty FIFO presents zero.
module aes256_block_fifo
    import aes256_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  aes_block_t               i_din,
    input  logic                     i_pop,
    output aes_block_t               o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    aes_block_t    r_mem [DEPTH];

    logic w_pop;
    logic w_push;

    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_level = r_cnt;
    assign o_dout  = o_empty ? '0 : r_mem[r_rd];

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else if (i_clear) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

    // Storage needs no reset: it is only visible through a non-zero count.
    always_ff @(posedge clk) begin
        if (w_push && !i_clear) r_mem[r_wr] <= i_din;
    end

endmodule

// File: rtl/aes256_byte_collector.sv
// Reassembles the serial ciphertext byte stream into 128-bit blocks,
// buffers them in a FIFO and throttles the upstream request when full.
module aes256_byte_collector
    import aes256_pkg::*;
#(
    parameter int DEPTH       = 2,
    parameter int BLOCK_BYTES = AES_BLOCK_BYTES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pi_byte_valid,
    input  logic [7:0]               pi_byte,
    output logic                     po_next_val_req,
    input  logic                     pi_clear,
    output logic                     po_block_valid,
    output aes_block_t               po_block,
    input  logic                     pi_block_ready,
    output logic [$clog2(DEPTH):0]   po_level,
    output logic                     po_overflow
);

    localparam int CW = $clog2(BLOCK_BYTES);
    localparam int AB = (BLOCK_BYTES - 1) * 8;
    localparam int LW = $clog2(DEPTH) + 1;

    coll_state_t   r_state;
    logic [CW-1:0] r_cnt;
    logic [AB-1:0] r_asm;
    logic          r_ovf;

    logic       w_accept;
    logic       w_commit;
    logic       w_pop;
    logic       w_fill;
    logic       w_empty;
    logic       w_full;
    aes_block_t w_block;

    assign w_accept = pi_byte_valid && (r_state != S_WAIT);
    assign w_commit = w_accept && (r_cnt == CW'(BLOCK_BYTES - 1));
    assign w_pop    = po_block_valid && pi_block_ready;
    assign w_block  = {r_asm, pi_byte};
    // Commit without a same-cycle pop into the last free slot fills the FIFO.
    assign w_fill   = w_commit && !w_pop && (po_level == LW'(DEPTH - 1));

    assign po_next_val_req = (r_state != S_WAIT);
    assign po_block_valid  = !w_empty;
    assign po_overflow     = r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_REQ;
            r_cnt   <= '0;
            r_asm   <= '0;
            r_ovf   <= 1'b0;
        end else if (pi_clear) begin
            r_state <= S_REQ;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if ((r_state == S_WAIT) && pi_byte_valid) r_ovf <= 1'b1;
            if (w_accept) begin
                r_asm <= {r_asm[AB-9:0], pi_byte};
                r_cnt <= r_cnt + 1'b1;
            end
            unique case (r_state)
                S_REQ:     if (w_accept) r_state <= S_COLLECT;
                S_COLLECT: if (w_commit) r_state <= w_fill ? S_WAIT : S_REQ;
                S_WAIT:    if (w_pop) r_state <= S_REQ;
                default:   r_state <= S_REQ;
            endcase
        end
    end

    aes256_block_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clear (pi_clear),
        .i_push  (w_commit),
        .i_din   (w_block),
        .i_pop   (pi_block_ready),
        .o_dout  (po_block),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (po_level)
    );

    logic w_unused;
    assign w_unused = w_full;

endmodule

// File: tb/tb_aes256_byte_collector.sv
// Scoreboard bench for aes256_byte_collector: driver updates a block-level
// model and queues expected blocks; a negedge monitor checks the DUT.
module tb_aes256_byte_collector;
    import aes256_pkg::*;

    localparam int DEPTH = 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   pi_byte_valid = 1'b0;
    logic [7:0]             pi_byte = 8'h00;
    logic                   po_next_val_req;
    logic                   pi_clear = 1'b0;
    logic                   po_block_valid;
    aes_block_t             po_block;
    logic                   pi_block_ready = 1'b0;
    logic [$clog2(DEPTH):0] po_level;
    logic                   po_overflow;

    int checks = 0;
    int errors = 0;

    aes_block_t sb[$];
    logic [7:0] part[$];
    int         m_level = 0;
    bit         m_blocked = 1'b0;
    bit         m_ovf = 1'b0;
    bit         mon_en = 1'b0;

    aes256_byte_collector #(
        .DEPTH       (DEPTH),
        .BLOCK_BYTES (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pi_byte_valid   (pi_byte_valid),
        .pi_byte         (pi_byte),
        .po_next_val_req (po_next_val_req),
        .pi_clear        (pi_clear),
        .po_block_valid  (po_block_valid),
        .po_block        (po_block),
        .pi_block_ready  (pi_block_ready),
        .po_level        (po_level),
        .po_overflow     (po_overflow)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        part.delete();
        sb.delete();
        m_level   = 0;
        m_blocked = 1'b0;
        m_ovf     = 1'b0;
    endfunction

    // Block-level behaviour of one clock edge, from the pre-edge inputs.
    function automatic void model(bit v, logic [7:0] b, bit rdy, bit clr);
        bit         pop;
        bit         commit;
        aes_block_t blk;
        if (clr) begin
            model_reset();
            return;
        end
        pop    = rdy && (m_level > 0);
        commit = 1'b0;
        if (v) begin
            if (m_blocked) begin
                m_ovf = 1'b1;
            end else begin
                part.push_back(b);
                if (part.size() == 16) begin
                    blk = '0;
                    foreach (part[i]) blk = {blk[119:0], part[i]};
                    sb.push_back(blk);
                    part.delete();
                    commit = 1'b1;
                end
            end
        end
        m_level = m_level + int'(commit) - int'(pop);
        if (m_blocked && pop) m_blocked = 1'b0;
        if (commit && (m_level == DEPTH)) m_blocked = 1'b1;
    endfunction

    task automatic step(bit v, logic [7:0] b, bit rdy, bit clr);
        pi_byte_valid  = v;
        pi_byte        = b;
        pi_block_ready = rdy;
        pi_clear       = clr;
        @(posedge clk);
        model(v, b, rdy, clr);
        #1;
        pi_byte_valid  = 1'b0;
        pi_byte        = 8'h00;
        pi_block_ready = 1'b0;
        pi_clear       = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && m_level > 0; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain_level", po_level, 0);
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                chk("level", po_level, m_level);
                chk("req", po_next_val_req, !m_blocked);
                chk("ovf", po_overflow, m_ovf);
                chk("valid", po_block_valid, m_level > 0);
                if (po_block_valid && sb.size() > 0) chk("head", po_block, sb[0]);
                if (po_block_valid && pi_block_ready && !pi_clear) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pop_unexpected got %h want none", po_block);
                    end else begin
                        chk("popped", po_block, sb.pop_front());
                    end
                end
            end
        end
    end

    logic [7:0] vec [16];

    initial begin : driver
        vec = '{8'h8e, 8'ha2, 8'hb7, 8'hca, 8'h51, 8'h67, 8'h45, 8'hbf,
                8'hea, 8'hfc, 8'h49, 8'h90, 8'h4b, 8'h49, 8'h60, 8'h89};

        #3;
        chk("rst_req", po_next_val_req, 1);
        chk("rst_valid", po_block_valid, 0);
        chk("rst_block", po_block, 0);
        chk("rst_level", po_level, 0);
        chk("rst_ovf", po_overflow, 0);
        #9;
        rst = 1'b0;
        model_reset();
        mon_en = 1'b1;

        // basic FIPS-197 vector
        for (int i = 0; i < 16; i++) step(1'b1, vec[i], 1'b1, 1'b0);
        chk("basic_valid", po_block_valid, 1);
        chk("basic_block", po_block, 128'h8ea2b7ca516745bfeafc49904b496089);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("basic_pulse", po_block_valid, 0);
        chk("basic_level", po_level, 0);

        // fill and back-pressure
        for (int i = 0; i < 32; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        chk("fill_level", po_level, 2);
        chk("fill_req", po_next_val_req, 0);
        step(1'b1, 8'hee, 1'b0, 1'b0);
        chk("fill_ovf", po_overflow, 1);
        chk("fill_level2", po_level, 2);

        // release one entry
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("rel_level", po_level, 1);
        chk("rel_req", po_next_val_req, 1);

        // push and pop in the same cycle
        for (int i = 0; i < 15; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        step(1'b1, 8'h5a, 1'b1, 1'b0);
        chk("pp_level", po_level, 1);
        chk("pp_low", po_block[7:0], 8'h5a);

        // clear mid-block
        drain();
        for (int i = 0; i < 7; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        step(1'b1, 8'hff, 1'b1, 1'b1);
        chk("clr_ovf", po_overflow, 0);
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        chk("clr_block", po_block, 128'h000102030405060708090a0b0c0d0e0f);
        drain();

        // asynchronous reset mid-block with full outputs
        for (int i = 0; i < 33; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("arst_req", po_next_val_req, 1);
        chk("arst_valid", po_block_valid, 0);
        chk("arst_block", po_block, 0);
        chk("arst_level", po_level, 0);
        chk("arst_ovf", po_overflow, 0);
        rst = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        chk("arst_block2", po_block, 128'h303132333435363738393a3b3c3d3e3f);
        drain();

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 9) < 7, 8'($urandom), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 99) < 2);
        end
        drain();
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes256_byte_collector.md
# aes256_byte_collector

Downstream stage of aes256_loading: consumes its serial 8-bit ciphertext stream (po_data / po_next_val_ready) and reassembles the bytes into 128-bit blocks. Completed blocks are held in a small FIFO and presented on a valid/ready handshake to the consumer. The block also generates the request back to aes256_loading (pi_next_val_req), deasserting it when no FIFO space remains. Partial blocks can be discarded, and dropped bytes are flagged.

## Interface
- DEPTH, 2, number of 128-bit block entries in the output FIFO (power of two, ≥2)
- BLOCK_BYTES, 16, bytes per block (fixed at 16 for AES; parameter exists only for the package constant)
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  reset, asynchronous, active-high
- pi_byte_valid  in  1  one-cycle strobe per valid byte; connect to aes256_loading po_next_val_ready
- pi_byte  in  8  byte data; connect to aes256_loading po_data
- po_next_val_req  out  1  request to upstream; connect to aes256_loading pi_next_val_req
- pi_clear  in  1  synchronous discard of the partial block and all FIFO contents
- po_block_valid  out  1  FIFO head holds a complete block
- po_block  out  128  FIFO head block; first received byte in [127:120]
- pi_block_ready  in  1  consumer accepts the head when high together with po_block_valid
- po_level  out  $clog2(DEPTH)+1  number of complete blocks stored
- po_overflow  out  1  sticky; a byte arrived while the collector was in S_WAIT

## Operation
- FSM states:
  - S_REQ: requesting; no bytes of the current block collected yet.
  - S_COLLECT: byte counter is 1..15.
  - S_WAIT: FIFO full; request is low.
- po_next_val_req = 1 in S_REQ and S_COLLECT, 0 in S_WAIT.
- Byte accept: in S_REQ or S_COLLECT, a pi_byte_valid strobe shifts pi_byte into the assembly register (shift left 8, new byte into [7:0]) and increments the 4-bit counter.
  - The first accepted byte in S_REQ moves the FSM to S_COLLECT.
- Commit: the accept that makes the counter wrap 15→0 writes assembly register || pi_byte into the FIFO tail. The counter wraps to 0.
  - If FIFO occupancy after this cycle equals DEPTH, next state is S_WAIT; otherwise S_REQ.
- Commit space guarantee: a commit can only occur outside S_WAIT. Therefore there is always space, counting a same-cycle pop.
- Pop: po_block_valid && pi_block_ready advances the head.
  - Push and pop in the same cycle leave po_level unchanged.
- S_WAIT exit: leave to S_REQ on the cycle after occupancy drops below DEPTH.
- pi_byte_valid in S_WAIT: the byte is dropped and po_overflow sets. Only rst or pi_clear clears po_overflow.
- pi_clear has priority over everything in the same cycle:
  - counter := 0, FIFO emptied, po_overflow := 0, state := S_REQ.
  - A byte strobe or pop in that cycle is ignored.
- Arithmetic: the FIFO pointers are $clog2(DEPTH)-bit and wrap naturally. Occupancy is one bit wider to distinguish full from empty.

## Timing
- Reset values:
  - po_next_val_req = 1, state S_REQ.
  - po_block_valid = 0, po_block = 0, po_level = 0, po_overflow = 0.
  - Counter and assembly register = 0.
- Latency: 16th byte strobe at edge N → po_block_valid = 1 and po_block valid after edge N (visible in cycle N+1).
- po_block is driven combinationally from the head entry. It is stable while po_block_valid = 1 and not popped.
- po_next_val_req falls in the cycle after the commit that fills the FIFO. It rises in the cycle after the pop that frees an entry.
  - Upstream may still deliver one in-flight byte after the fall; that byte counts as overflow. Upstream must not rely on zero-latency deassertion.
- Reset mid-block: the partial block is lost, with no output.
- Back-to-back strobes, one per cycle, are supported at full rate.

## Structure
- aes256_pkg holds:
  - AES_BLOCK_BITS = 128 and AES_BLOCK_BYTES = 16.
  - The collector state enum typedef (S_REQ, S_COLLECT, S_WAIT).
  - The typedef aes_block_t for logic [127:0].
- One sub-module, aes256_block_fifo: parameterised DEPTH × 128-bit synchronous FIFO with push/pop, full/empty and level, using the same clk/rst.
- The collector top contains the FSM, the byte counter, the assembly register and the overflow flag.

## Test plan
1. **Basic vector.** Drive the 16 bytes 8e a2 b7 ca 51 67 45 bf ea fc 49 90 4b 49 60 89 (FIPS-197 AES-256 ciphertext) one per cycle, with pi_block_ready = 1. Required: po_block_valid pulses for exactly one cycle, po_block = 128'h8ea2b7ca516745bfeafc49904b496089, po_level returns to 0.
2. **Fill and back-pressure.** Hold pi_block_ready = 0 and send 2×16 bytes. Required: po_level = 2, po_next_val_req = 0 from the cycle after byte 32. Then send one extra byte: po_overflow = 1 and po_level stays 2.
3. **Release.** From the state at the end of scenario 2, pulse pi_block_ready for one cycle. Required: po_level = 1, po_next_val_req = 1 on the next cycle, and the head is now the second block.
4. **Simultaneous push/pop.** With one block stored, make byte 16 of the next block coincide with a pop. Required: po_level stays 1, and the next head equals the new block.
5. **Clear and reset.** After 7 bytes, assert pi_clear. Then send 16 bytes 00..0f. Required: po_block = 128'h000102030405060708090a0b0c0d0e0f. Repeat the scenario with an asynchronous rst pulse mid-block. Required: all outputs return to their reset values immediately, without waiting for a clock edge.
